// File: rtl/bundle_lane_serializer_if.sv
// Handshake bundle for the lane serializer: parallel bundle in, serial beat stream out.
// master drives the bundle and sinks beats; slave is the serializer.
`timescale 1ns/1ps
interface bundle_lane_serializer_if #(
   parameter int WIDTH = 3
);
   logic             in_valid;
   logic [WIDTH-1:0] in_lane_0;
   logic [WIDTH-1:0] in_lane_1;
   logic [WIDTH-1:0] in_lane_2;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_ready;

   modport master (
      output in_valid, in_lane_0, in_lane_1, in_lane_2,
      input  in_ready,
      input  out_valid, out_data, out_last,
      output out_ready
   );

   modport slave (
      input  in_valid, in_lane_0, in_lane_1, in_lane_2,
      output in_ready,
      output out_valid, out_data, out_last,
      input  out_ready
   );
endinterface

// File: rtl/bundle_lane_serializer.sv
// Captures a 3-lane bundle per handshake and replays it as lane 0, 1, 2 and an
// optional wrap-around checksum beat, with back-to-back frames and no bubble.
`timescale 1ns/1ps
module bundle_lane_serializer #(
   parameter int WIDTH      = 3,
   parameter int APPEND_SUM = 1,
   parameter int CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   bundle_lane_serializer_if.slave bus,
   output logic                 busy,
   output logic [CNT_W-1:0]     frame_count
);

   typedef enum logic [1:0] {IDLE, SEND, SUM} state_t;

   state_t           state, state_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [WIDTH-1:0] lane_0_q, lane_1_q, lane_2_q, sum_q;
   logic [WIDTH-1:0] lane_sel;
   logic             load, done;

   function automatic logic [WIDTH-1:0] lane_sum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c);
      return a + b + c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   always_comb begin
      case (idx)
         2'd0:    lane_sel = lane_0_q;
         2'd1:    lane_sel = lane_1_q;
         default: lane_sel = lane_2_q;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      load          = 1'b0;
      done          = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_last  = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               load      = 1'b1;
               idx_nxt   = 2'd0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            bus.out_valid = 1'b1;
            bus.out_data  = lane_sel;
            bus.out_last  = (idx == 2'd2) && (APPEND_SUM == 0);
            if (bus.out_ready) begin
               if (idx != 2'd2)         idx_nxt   = idx + 2'd1;
               else if (APPEND_SUM != 0) state_nxt = SUM;
               else                      done      = 1'b1;
            end
         end
         SUM: begin
            bus.out_valid = 1'b1;
            bus.out_data  = sum_q;
            bus.out_last  = 1'b1;
            if (bus.out_ready) done = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      // Final-beat handshake reopens the input in the same cycle so frames chain without a gap.
      if (done) begin
         bus.in_ready = 1'b1;
         if (bus.in_valid) begin
            load      = 1'b1;
            idx_nxt   = 2'd0;
            state_nxt = SEND;
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= 2'd0;
         lane_0_q    <= '0;
         lane_1_q    <= '0;
         lane_2_q    <= '0;
         sum_q       <= '0;
         frame_count <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (load) begin
            lane_0_q <= bus.in_lane_0;
            lane_1_q <= bus.in_lane_1;
            lane_2_q <= bus.in_lane_2;
            sum_q    <= lane_sum(bus.in_lane_0, bus.in_lane_1, bus.in_lane_2);
         end
         if (done) frame_count <= sat_inc(frame_count);
      end
   end

   assign busy = (state != IDLE);

endmodule
